// File: rtl/pcpu_sim_mem.sv
// Instruction ROM / data RAM model for PCPU with programming port, halt detection and store/cycle accounting.
// Latency: i_datain 1 clock after i_addr; d_datain RD_LAT clocks after d_addr, fully pipelined.
// Backpressure: none; every input is accepted or dropped on the edge it is sampled.
module pcpu_sim_mem #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 8,
   parameter int unsigned IDEPTH  = 256,
   parameter int unsigned DDEPTH  = 256,
   parameter int unsigned RD_LAT  = 3,
   parameter logic [4:0]  HALT_OP = 5'b00001,
   parameter int unsigned CW      = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          run,
   input  logic          prog_we,
   input  logic          prog_sel,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   output logic          prog_err,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_datain,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_dataout,
   input  logic          d_we,
   output logic [DW-1:0] d_datain,
   output logic          halted,
   output logic [CW-1:0] cycle_cnt,
   output logic [CW-1:0] store_cnt,
   output logic [AW-1:0] last_st_addr,
   output logic [DW-1:0] last_st_data
);

   localparam int unsigned IAW = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
   localparam int unsigned DAW = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
   localparam logic [AW:0] IDEPTH_L = IDEPTH[AW:0];
   localparam logic [AW:0] DDEPTH_L = DDEPTH[AW:0];

   logic [DW-1:0] r_imem [IDEPTH];
   logic [DW-1:0] r_dmem [DDEPTH];
   logic [DW-1:0] r_dpipe [RD_LAT];

   logic [DW-1:0] r_i_datain;
   logic          r_prog_err;
   logic          r_halted;
   logic [CW-1:0] r_cycle_cnt;
   logic [CW-1:0] r_store_cnt;
   logic [AW-1:0] r_last_st_addr;
   logic [DW-1:0] r_last_st_data;

   logic          w_i_in;
   logic          w_d_in;
   logic          w_prog_in;
   logic          w_prog_i;
   logic          w_prog_d;
   logic          w_store;
   logic [DAW-1:0] w_dwa;
   logic [DW-1:0] w_dwd;

   assign w_i_in    = ({1'b0, i_addr} < IDEPTH_L);
   assign w_d_in    = ({1'b0, d_addr} < DDEPTH_L);
   assign w_prog_in = prog_sel ? ({1'b0, prog_addr} < DDEPTH_L) : ({1'b0, prog_addr} < IDEPTH_L);
   assign w_prog_i  = !run && prog_we && !prog_sel && w_prog_in;
   assign w_prog_d  = !run && prog_we &&  prog_sel && w_prog_in;
   // A store after halt is dropped; the store on the edge that sets halted still lands.
   assign w_store   = run && d_we && w_d_in && !r_halted;
   // Programming needs run=0 and stores need run=1, so the two never collide on the data port.
   assign w_dwa     = w_store ? d_addr[DAW-1:0] : prog_addr[DAW-1:0];
   assign w_dwd     = w_store ? d_dataout : prog_data;

   // Memory writes; contents are never cleared so a reset keeps the loaded program.
   always_ff @(posedge clock) begin
      if (!reset && w_prog_i) begin
         r_imem[prog_addr[IAW-1:0]] <= prog_data;
      end
      if (!reset && (w_prog_d || w_store)) begin
         r_dmem[w_dwa] <= w_dwd;
      end
   end

   // Load pipeline: stage 0 reads the old word (read-first against a same-edge store).
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < int'(RD_LAT); k++) begin
            r_dpipe[k] <= '0;
         end
      end else begin
         r_dpipe[0] <= w_d_in ? r_dmem[d_addr[DAW-1:0]] : '0;
         for (int k = 1; k < int'(RD_LAT); k++) begin
            r_dpipe[k] <= r_dpipe[k-1];
         end
      end
   end

   // Fetch, error pulse, halt latch and saturating accounting.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_i_datain     <= '0;
         r_prog_err     <= 1'b0;
         r_halted       <= 1'b0;
         r_cycle_cnt    <= '0;
         r_store_cnt    <= '0;
         r_last_st_addr <= '0;
         r_last_st_data <= '0;
      end else begin
         r_i_datain <= (run && w_i_in) ? r_imem[i_addr[IAW-1:0]] : '0;
         r_prog_err <= run && prog_we;
         if (run && (r_i_datain[DW-1:DW-5] == HALT_OP)) begin
            r_halted <= 1'b1;
         end
         if (run && !r_halted && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + CW'(1);
         end
         if (w_store) begin
            if (r_store_cnt != '1) begin
               r_store_cnt <= r_store_cnt + CW'(1);
            end
            r_last_st_addr <= d_addr;
            r_last_st_data <= d_dataout;
         end
      end
   end

   assign i_datain     = r_i_datain;
   assign d_datain     = r_dpipe[RD_LAT-1];
   assign prog_err     = r_prog_err;
   assign halted       = r_halted;
   assign cycle_cnt    = r_cycle_cnt;
   assign store_cnt    = r_store_cnt;
   assign last_st_addr = r_last_st_addr;
   assign last_st_data = r_last_st_data;

endmodule

// File: tb/tb_pcpu_sim_mem.sv
// Bench for pcpu_sim_mem: three instances (load latency 3/1/4, counter width 32/4/16) share one stimulus.
// A queue/array model predicts every output each cycle; directed literal checks pin the model.
// Inputs change on the falling edge; outputs are compared 1 time unit after the rising edge.
module tb_pcpu_sim_mem;
   localparam int DEP = 200;

   logic        clock, reset, run, prog_we, prog_sel, d_we;
   logic [7:0]  prog_addr, i_addr, d_addr;
   logic [15:0] prog_data, d_dataout;

   logic [15:0] a_id, b_id, c_id, a_dd, b_dd, c_dd, a_ld, b_ld, c_ld;
   logic        a_pe, b_pe, c_pe, a_h, b_h, c_h;
   logic [31:0] a_cc, a_sc;
   logic [3:0]  b_cc, b_sc;
   logic [15:0] c_cc, c_sc;
   logic [7:0]  a_la, b_la, c_la;

   int n_chk = 0;
   int n_fail = 0;
   int lat_of [3] = '{3, 1, 4};
   int cw_of  [3] = '{32, 4, 16};

   pcpu_sim_mem #(.IDEPTH(DEP), .DDEPTH(DEP), .RD_LAT(3), .CW(32)) u_a (
      .clock(clock), .reset(reset), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(a_pe), .i_addr(i_addr),
      .i_datain(a_id), .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(a_dd),
      .halted(a_h), .cycle_cnt(a_cc), .store_cnt(a_sc), .last_st_addr(a_la), .last_st_data(a_ld));
   pcpu_sim_mem #(.IDEPTH(DEP), .DDEPTH(DEP), .RD_LAT(1), .CW(4)) u_b (
      .clock(clock), .reset(reset), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(b_pe), .i_addr(i_addr),
      .i_datain(b_id), .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(b_dd),
      .halted(b_h), .cycle_cnt(b_cc), .store_cnt(b_sc), .last_st_addr(b_la), .last_st_data(b_ld));
   pcpu_sim_mem #(.IDEPTH(DEP), .DDEPTH(DEP), .RD_LAT(4), .CW(16)) u_c (
      .clock(clock), .reset(reset), .run(run), .prog_we(prog_we), .prog_sel(prog_sel),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(c_pe), .i_addr(i_addr),
      .i_datain(c_id), .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(c_dd),
      .halted(c_h), .cycle_cnt(c_cc), .store_cnt(c_sc), .last_st_addr(c_la), .last_st_data(c_ld));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   typedef struct { logic [15:0] v; bit k; } rd_t;
   logic [15:0] m_imem [256];
   bit          m_iv   [256];
   logic [15:0] m_dmem [256];
   bit          m_dv   [256];
   logic [15:0] m_if;
   bit          m_ifv, m_halt, m_err;
   longint      m_cyc, m_st;
   logic [7:0]  m_la;
   logic [15:0] m_ld;
   rd_t         hist [$];

   function automatic longint sat(input longint v, input int cw);
      longint mx;
      mx = (longint'(1) << cw) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      rd_t r;
      logic [15:0] old_if;
      bit old_ifv, old_halt;
      if (reset) begin
         m_if = '0; m_ifv = 1'b1; m_halt = 1'b0; m_err = 1'b0;
         m_cyc = 0; m_st = 0; m_la = '0; m_ld = '0;
         hist.delete();
      end else begin
         old_if = m_if; old_ifv = m_ifv; old_halt = m_halt;
         if (int'(d_addr) < DEP) begin r.v = m_dmem[d_addr]; r.k = m_dv[d_addr]; end
         else begin r.v = '0; r.k = 1'b1; end
         hist.push_back(r);
         if (hist.size() > 8) void'(hist.pop_front());
         if (run && int'(i_addr) < DEP) begin m_if = m_imem[i_addr]; m_ifv = m_iv[i_addr]; end
         else begin m_if = '0; m_ifv = 1'b1; end
         m_err = run && prog_we;
         if (run && !old_halt) m_cyc++;
         if (run && old_ifv && old_if[15:11] == 5'b00001) m_halt = 1'b1;
         if (run && d_we && int'(d_addr) < DEP && !old_halt) begin
            m_dmem[d_addr] = d_dataout; m_dv[d_addr] = 1'b1;
            m_st++; m_la = d_addr; m_ld = d_dataout;
         end
         if (!run && prog_we && int'(prog_addr) < DEP) begin
            if (prog_sel) begin m_dmem[prog_addr] = prog_data; m_dv[prog_addr] = 1'b1; end
            else begin m_imem[prog_addr] = prog_data; m_iv[prog_addr] = 1'b1; end
         end
      end
   endtask

   task automatic cmp_one(input int u, input logic [15:0] id, input logic [15:0] dd,
                          input logic pe, input logic h, input longint cc, input longint sc,
                          input logic [7:0] la, input logic [15:0] ld);
      rd_t e;
      int L;
      L = lat_of[u];
      if (hist.size() >= L) e = hist[hist.size() - L];
      else begin e.v = '0; e.k = 1'b1; end
      if (m_ifv) chk($sformatf("u%0d.i_datain", u), longint'(id), longint'(m_if));
      if (e.k)   chk($sformatf("u%0d.d_datain", u), longint'(dd), longint'(e.v));
      chk($sformatf("u%0d.prog_err", u), longint'(pe), longint'(m_err));
      chk($sformatf("u%0d.halted", u), longint'(h), longint'(m_halt));
      chk($sformatf("u%0d.cycle_cnt", u), cc, sat(m_cyc, cw_of[u]));
      chk($sformatf("u%0d.store_cnt", u), sc, sat(m_st, cw_of[u]));
      chk($sformatf("u%0d.last_st_addr", u), longint'(la), longint'(m_la));
      chk($sformatf("u%0d.last_st_data", u), longint'(ld), longint'(m_ld));
   endtask

   // compare process: advance the model on each rising edge, then check all three instances
   always @(posedge clock) begin
      model_step();
      #1;
      cmp_one(0, a_id, a_dd, a_pe, a_h, longint'(a_cc), longint'(a_sc), a_la, a_ld);
      cmp_one(1, b_id, b_dd, b_pe, b_h, longint'(b_cc), longint'(b_sc), b_la, b_ld);
      cmp_one(2, c_id, c_dd, c_pe, c_h, longint'(c_cc), longint'(c_sc), c_la, c_ld);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic prog(input logic sel, input logic [7:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   logic [15:0] itab [16] = '{16'h1000, 16'h1101, 16'h0000, 16'h0000, 16'h0000, 16'h2312,
                              16'h0000, 16'h0000, 16'h0000, 16'h1B02, 16'h0800, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000};
   logic [15:0] dtab [8]  = '{16'h00AB, 16'h3C00, 16'h0202, 16'h0303,
                              16'h0404, 16'h1111, 16'h0606, 16'h0707};
   logic [15:0] gr1, gr2;

   initial begin
      reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0;
      prog_data = '0; i_addr = '0; d_addr = '0; d_dataout = '0; d_we = 1'b0;
      gr1 = '0; gr2 = '0;
      tick(); tick();
      chk("rst_cycle_cnt", longint'(a_cc), 0);
      chk("rst_store_cnt", longint'(a_sc), 0);
      chk("rst_halted", longint'(a_h), 0);
      chk("rst_d_datain", longint'(a_dd), 0);
      reset = 1'b0;

      // preload
      for (int k = 0; k < 16; k++) prog(1'b0, 8'(k), itab[k]);
      for (int k = 0; k < 8; k++)  prog(1'b1, 8'(k), dtab[k]);

      // back-to-back load sweep, all three latencies
      run = 1'b1; i_addr = 8'd2;
      for (int k = 0; k < 8; k++) begin
         d_addr = 8'(k);
         tick();
         chk("lat1_sweep", longint'(b_dd), longint'(dtab[k]));
         if (k >= 2) chk("lat3_sweep", longint'(a_dd), longint'(dtab[k-2]));
         if (k >= 3) chk("lat4_sweep", longint'(c_dd), longint'(dtab[k-3]));
      end
      d_addr = 8'd0;
      repeat (4) tick();

      // same-edge store and load at address 5: old value loaded
      d_addr = 8'd5; d_we = 1'b1; d_dataout = 16'h2222;
      tick();
      chk("rdfirst_lat1", longint'(b_dd), 16'h1111);
      d_we = 1'b0; d_addr = 8'd6;
      tick(); tick();
      chk("rdfirst_lat3", longint'(a_dd), 16'h1111);
      d_addr = 8'd5;
      tick();
      chk("reread_lat1", longint'(b_dd), 16'h2222);
      d_addr = 8'd6;
      tick(); tick();
      chk("reread_lat3", longint'(a_dd), 16'h2222);

      // programming while running is refused and flagged once
      prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 8'd5; prog_data = 16'hBEEF;
      tick();
      prog_we = 1'b0;
      chk("prog_err_pulse", longint'(a_pe), 1);
      d_addr = 8'd5;
      tick();
      chk("prog_err_clear", longint'(a_pe), 0);
      chk("prog_no_write", longint'(b_dd), 16'h2222);
      i_addr = 8'd200;
      tick();
      chk("fetch_oor", longint'(a_id), 0);

      // program run acting as the CPU
      reset = 1'b1; i_addr = 8'd0;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 15; c++) begin
         i_addr = (c <= 10) ? 8'(c) : 8'd11;
         d_we = (c == 9) || (c == 11) || (c == 12);
         case (c)
            1:  d_addr = 8'd1;
            9:  d_addr = 8'd2;
            11: d_addr = 8'd3;
            12: d_addr = 8'd4;
            default: d_addr = 8'd0;
         endcase
         d_dataout = (c == 9) ? (gr1 + gr2) : ((c == 11) ? 16'h5555 : 16'h6666);
         tick();
         if (c == 2) gr1 = a_dd;
         if (c == 3) gr2 = a_dd;
         if (c == 9) begin
            chk("prog_store_cnt", longint'(a_sc), 1);
            chk("prog_last_addr", longint'(a_la), 8'h02);
            chk("prog_last_data", longint'(a_ld), 16'h3CAB);
         end
         if (c == 10) chk("fetch_halt_op", longint'(a_id), 16'h0800);
         if (c == 11) chk("halted_set", longint'(a_h), 1);
      end
      d_we = 1'b0;
      chk("halt_store_cnt", longint'(a_sc), 2);
      chk("halt_last_addr", longint'(a_la), 8'h03);
      chk("cycle_frozen", longint'(a_cc), 12);
      d_addr = 8'd2;
      tick();
      chk("dmem2_result", longint'(b_dd), 16'h3CAB);
      d_addr = 8'd4;
      tick();
      chk("dmem4_dropped", longint'(b_dd), 16'h0404);

      // reset in the middle of a run
      reset = 1'b1; i_addr = 8'd2;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin d_addr = 8'(k % 8); tick(); end
      chk("run10_cycle_cnt", longint'(a_cc), 10);
      reset = 1'b1; d_addr = 8'd2;
      tick();
      chk("midrst_cycle", longint'(a_cc), 0);
      chk("midrst_store", longint'(a_sc), 0);
      chk("midrst_halted", longint'(a_h), 0);
      chk("midrst_idat", longint'(a_id), 0);
      chk("midrst_ddat", longint'(a_dd), 0);
      chk("midrst_last", longint'(a_la), 0);
      reset = 1'b0;
      tick();
      chk("restart_cycle", longint'(a_cc), 1);
      chk("mem_retained", longint'(b_dd), 16'h3CAB);

      // store counter saturation on the 4-bit instance
      for (int k = 0; k < 20; k++) begin
         d_we = 1'b1; d_addr = 8'(100 + k); d_dataout = 16'(k);
         tick();
      end
      d_addr = 8'd250; d_dataout = 16'hFFFF;
      tick();
      d_we = 1'b0; d_addr = 8'd0;
      chk("sat_store_cw4", longint'(b_sc), 15);
      chk("sat_cycle_cw4", longint'(b_cc), 15);
      chk("store_cnt_cw32", longint'(a_sc), 20);
      chk("store_cnt_cw16", longint'(c_sc), 20);
      chk("oor_store_last", longint'(a_la), 8'd119);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
